// File: rtl/timer_presc_pkg.sv
// Shared types and defaults for the timer unit prescaler/counter.
package timer_presc_pkg;

    localparam int unsigned CNT_WIDTH_DEFAULT = 32;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } presc_state_e;

endpackage

// File: rtl/timer_unit_presc_fsm.sv
// Prescaler/counter with IDLE/RUN/DONE control, one-shot mode and upstream enable.
// The count wraps to 0 after reaching compare, emitting one tick per wrap.
module timer_unit_presc_fsm
    import timer_presc_pkg::*;
#(
    parameter int unsigned CNT_WIDTH = CNT_WIDTH_DEFAULT
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_i,
    input  logic                 stop_i,
    input  logic                 clear_i,
    input  logic                 oneshot_i,
    input  logic                 en_i,
    input  logic                 write_counter_i,
    input  logic [CNT_WIDTH-1:0] counter_value_i,
    input  logic [CNT_WIDTH-1:0] compare_value_i,
    output logic [CNT_WIDTH-1:0] counter_value_o,
    output logic                 tick_o,
    output logic                 busy_o,
    output logic                 done_o
);

    presc_state_e         state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 tick_q, tick_d;
    logic                 done_q, done_d;
    logic                 busy_q;

    // Controls are mutually prioritised: clear > load > stop > start > counting.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tick_d  = 1'b0;
        done_d  = done_q;

        if (clear_i) begin
            state_d = IDLE;
            cnt_d   = '0;
            done_d  = 1'b0;
        end else if (write_counter_i) begin
            cnt_d = counter_value_i;
        end else if (stop_i && (state_q == RUN)) begin
            state_d = IDLE;
        end else if (start_i && (state_q != RUN)) begin
            state_d = RUN;
            cnt_d   = '0;
            done_d  = 1'b0;
        end else if ((state_q == RUN) && en_i) begin
            if (cnt_q == compare_value_i) begin
                cnt_d  = '0;
                tick_d = 1'b1;
                if (oneshot_i) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end
            end else begin
                // Counts above compare roll over naturally without a tick.
                cnt_d = cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            tick_q  <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tick_q  <= tick_d;
            done_q  <= done_d;
            busy_q  <= (state_d == RUN);
        end
    end

    assign counter_value_o = cnt_q;
    assign tick_o          = tick_q;
    assign busy_o          = busy_q;
    assign done_o          = done_q;

endmodule

// File: tb/tb_timer_unit_presc_fsm.sv
// Directed self-checking bench for timer_unit_presc_fsm with an 8-bit counter.
module tb_timer_unit_presc_fsm;

    localparam int unsigned W = 8;

    logic         clk_i = 1'b0;
    logic         rst_ni;
    logic         start_i, stop_i, clear_i, oneshot_i, en_i, write_counter_i;
    logic [W-1:0] counter_value_i, compare_value_i;
    logic [W-1:0] counter_value_o;
    logic         tick_o, busy_o, done_o;

    int passed = 0;
    int total  = 0;

    logic [W+2:0] obs;
    logic [W+2:0] exp_v;

    assign obs = {busy_o, done_o, tick_o, counter_value_o};

    timer_unit_presc_fsm #(.CNT_WIDTH(W)) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .start_i         (start_i),
        .stop_i          (stop_i),
        .clear_i         (clear_i),
        .oneshot_i       (oneshot_i),
        .en_i            (en_i),
        .write_counter_i (write_counter_i),
        .counter_value_i (counter_value_i),
        .compare_value_i (compare_value_i),
        .counter_value_o (counter_value_o),
        .tick_o          (tick_o),
        .busy_o          (busy_o),
        .done_o          (done_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_clear();
        clear_i = 1'b1;
        step();
        clear_i = 1'b0;
    endtask

    task automatic do_start();
        start_i = 1'b1;
        step();
        start_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_ni = 1'b1;
        #2 rst_ni = 1'b0;
        #2;
        total++;
        if (obs !== '0) $display("[TB] FAIL reset_values: got %h expected %h", obs, 11'h0);
        else passed++;
        @(negedge clk_i);
        rst_ni = 1'b1;
        step();
        total++;
        if (obs !== '0) $display("[TB] FAIL idle_after_reset: got %h expected %h", obs, 11'h0);
        else passed++;
    endtask

    // compare=2: counts 0,1,2 then tick on the wrap, every 3 cycles.
    task automatic test_continuous();
        compare_value_i = 8'd2;
        oneshot_i = 1'b0;
        do_start();
        for (int c = 1; c <= 14; c++) begin
            exp_v = {1'b1, 1'b0, (c >= 4) && ((c - 1) % 3 == 0), 8'((c - 1) % 3)};
            total++;
            if (obs !== exp_v) $display("[TB] FAIL continuous_c%0d: got %h expected %h", c, obs, exp_v);
            else passed++;
            if (c < 14) step();
        end
        // cycle 14 shows count 1; stop holds it
        stop_i = 1'b1;
        step();
        stop_i = 1'b0;
        exp_v = {1'b0, 1'b0, 1'b0, 8'd1};
        total++;
        if (obs !== exp_v) $display("[TB] FAIL stop_hold: got %h expected %h", obs, exp_v);
        else passed++;
        step();
        total++;
        if (obs !== exp_v) $display("[TB] FAIL idle_hold: got %h expected %h", obs, exp_v);
        else passed++;
        do_clear();
    endtask

    task automatic test_oneshot();
        compare_value_i = 8'd3;
        oneshot_i = 1'b1;
        do_start();
        for (int c = 1; c <= 8; c++) begin
            exp_v = {c < 5, c >= 5, c == 5, (c < 5) ? 8'(c - 1) : 8'd0};
            total++;
            if (obs !== exp_v) $display("[TB] FAIL oneshot_c%0d: got %h expected %h", c, obs, exp_v);
            else passed++;
            if (c < 8) step();
        end
        // load still works in DONE
        counter_value_i = 8'h42;
        write_counter_i = 1'b1;
        step();
        write_counter_i = 1'b0;
        exp_v = {1'b0, 1'b1, 1'b0, 8'h42};
        total++;
        if (obs !== exp_v) $display("[TB] FAIL done_load: got %h expected %h", obs, exp_v);
        else passed++;
        do_start();
        exp_v = {1'b1, 1'b0, 1'b0, 8'd0};
        total++;
        if (obs !== exp_v) $display("[TB] FAIL restart_from_done: got %h expected %h", obs, exp_v);
        else passed++;
        oneshot_i = 1'b0;
        do_clear();
    endtask

    // compare=1 with en_i high only on odd cycles: tick every 4 cycles.
    task automatic test_en_gating();
        logic [7:0] exp_cnt [2:9];
        logic       exp_tck [2:9];
        exp_cnt = '{8'd1, 8'd1, 8'd0, 8'd0, 8'd1, 8'd1, 8'd0, 8'd0};
        exp_tck = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        compare_value_i = 8'd1;
        do_start();
        for (int c = 1; c <= 8; c++) begin
            en_i = (c % 2 == 1);
            step();
            exp_v = {1'b1, 1'b0, exp_tck[c+1], exp_cnt[c+1]};
            total++;
            if (obs !== exp_v) $display("[TB] FAIL en_gate_c%0d: got %h expected %h", c + 1, obs, exp_v);
            else passed++;
        end
        en_i = 1'b1;
        do_clear();
    endtask

    task automatic test_load_above_compare();
        logic [7:0] seq [0:8];
        seq = '{8'hFF, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h00, 8'h01};
        compare_value_i = 8'd5;
        do_start();
        counter_value_i = 8'hFE;
        write_counter_i = 1'b1;
        step();
        write_counter_i = 1'b0;
        exp_v = {1'b1, 1'b0, 1'b0, 8'hFE};
        total++;
        if (obs !== exp_v) $display("[TB] FAIL load_fe: got %h expected %h", obs, exp_v);
        else passed++;
        for (int i = 0; i < 9; i++) begin
            step();
            exp_v = {1'b1, 1'b0, i == 7, seq[i]};
            total++;
            if (obs !== exp_v) $display("[TB] FAIL load_seq_%0d: got %h expected %h", i, obs, exp_v);
            else passed++;
        end
        do_clear();
    endtask

    task automatic test_compare_zero();
        compare_value_i = 8'd0;
        do_start();
        for (int c = 2; c <= 4; c++) begin
            step();
            exp_v = {1'b1, 1'b0, 1'b1, 8'd0};
            total++;
            if (obs !== exp_v) $display("[TB] FAIL cmp0_c%0d: got %h expected %h", c, obs, exp_v);
            else passed++;
        end
        do_clear();
    endtask

    task automatic test_priority();
        compare_value_i = 8'd100;
        do_start();
        step();
        step();
        clear_i = 1'b1;
        write_counter_i = 1'b1;
        counter_value_i = 8'h33;
        start_i = 1'b1;
        step();
        clear_i = 1'b0;
        write_counter_i = 1'b0;
        start_i = 1'b0;
        exp_v = '0;
        total++;
        if (obs !== exp_v) $display("[TB] FAIL prio_clear: got %h expected %h", obs, exp_v);
        else passed++;
        do_start();
        step();
        step();
        stop_i = 1'b1;
        start_i = 1'b1;
        step();
        stop_i = 1'b0;
        start_i = 1'b0;
        exp_v = {1'b0, 1'b0, 1'b0, 8'd2};
        total++;
        if (obs !== exp_v) $display("[TB] FAIL prio_stop_start: got %h expected %h", obs, exp_v);
        else passed++;
        do_clear();
    endtask

    task automatic test_reset_mid_run();
        compare_value_i = 8'd100;
        do_start();
        for (int i = 0; i < 7; i++) step();
        exp_v = {1'b1, 1'b0, 1'b0, 8'd7};
        total++;
        if (obs !== exp_v) $display("[TB] FAIL pre_reset_count: got %h expected %h", obs, exp_v);
        else passed++;
        rst_ni = 1'b0;
        #1;
        total++;
        if (obs !== '0) $display("[TB] FAIL async_reset: got %h expected %h", obs, 11'h0);
        else passed++;
        #2 rst_ni = 1'b1;
        do_start();
        step();
        step();
        exp_v = {1'b1, 1'b0, 1'b0, 8'd2};
        total++;
        if (obs !== exp_v) $display("[TB] FAIL resume_after_reset: got %h expected %h", obs, exp_v);
        else passed++;
    endtask

    initial begin
        start_i = 1'b0;
        stop_i = 1'b0;
        clear_i = 1'b0;
        oneshot_i = 1'b0;
        en_i = 1'b1;
        write_counter_i = 1'b0;
        counter_value_i = '0;
        compare_value_i = 8'd2;
        test_reset();
        test_continuous();
        test_oneshot();
        test_en_gating();
        test_load_above_compare();
        test_compare_zero();
        test_priority();
        test_reset_mid_run();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/timer_unit_presc_fsm.md
# timer_unit_presc_fsm

Parametrised prescaler/counter for the APB timer unit, successor to the fixed 32-bit prescaler counter. It adds a configurable width, an explicit IDLE/RUN/DONE state machine, a one-shot mode, and an upstream enable that lets it cascade with other counters. It sits between the APB register file and the timer counters, and its `tick_o` drives their enable inputs.

## Interface
- `CNT_WIDTH`, default 32: counter, load and compare width (legal range 2..32)
- `clk_i` in, 1: clock
- `rst_ni` in, 1: reset, asynchronous, active-low
- `start_i` in, 1: pulse; start counting from 0
- `stop_i` in, 1: pulse; halt and hold the count
- `clear_i` in, 1: pulse; zero the count, return to IDLE, clear `done_o`
- `oneshot_i` in, 1: level; 1 = stop after first wrap, 0 = continuous
- `en_i` in, 1: level; counting qualifier from upstream (tie to 1 if unused)
- `write_counter_i` in, 1: pulse; load `counter_value_i`
- `counter_value_i` in, CNT_WIDTH: load value
- `compare_value_i` in, CNT_WIDTH: wrap point; period is compare+1 enabled cycles
- `counter_value_o` out, CNT_WIDTH: current count (register)
- `tick_o` out, 1: one-cycle pulse per wrap (register)
- `busy_o` out, 1: state == RUN
- `done_o` out, 1: sticky; one-shot has completed

## Operation
- States: IDLE (reset), RUN, DONE.
- Control priority, evaluated each cycle: `clear_i` > `write_counter_i` > `stop_i` > `start_i` > counting.
- `clear_i`: count := 0, state := IDLE, `done_o` := 0, `tick_o` := 0.
- `write_counter_i`: count := `counter_value_i`; state unchanged; no tick that cycle.
- `stop_i` in RUN: state := IDLE, count held. Ignored in IDLE and DONE.
- `start_i` in IDLE or DONE: count := 0, state := RUN, `done_o` := 0. Ignored in RUN, so there is no restart.
- Counting in RUN with `en_i`=1:
  - If count == `compare_value_i`: count := 0, `tick_o` := 1.
    - If `oneshot_i`=1 at that cycle, state := DONE and `done_o` := 1.
  - Otherwise count := count+1 modulo 2^CNT_WIDTH.
- RUN with `en_i`=0: count held, no tick.
- DONE: count stays 0 until `start_i` or `clear_i`. `write_counter_i` still loads.
- Compare is combinational on the registered count against live `compare_value_i`. Changing compare mid-run takes effect immediately.
- Loaded or live count above compare: counts up to 2^CNT_WIDTH−1, wraps naturally to 0 with no tick, then continues until it equals compare.
- compare = 0: tick on every enabled cycle.

## Timing
- Reset values: state IDLE, `counter_value_o`=0, `tick_o`=0, `busy_o`=0, `done_o`=0.
- Every control input acts on the next clock edge, with one cycle of latency to the outputs.
- Example: `start_i` in cycle 0, compare=2, `en_i`=1:
  - cycle 1: RUN, count 0
  - cycle 2: count 1
  - cycle 3: count 2
  - cycle 4: count 0, `tick_o`=1
  - ticks then repeat every 3 cycles
- `tick_o` is high in the cycle the count shows 0 after a compare wrap. It never lasts more than one cycle per wrap.
- `done_o` rises in the same cycle as the final `tick_o`. `busy_o` falls in that cycle.
- Reset asserted mid-run: all state returns to reset values asynchronously.

## Structure
- Package `timer_presc_pkg` holds:
  - the state enum `presc_state_e` {IDLE, RUN, DONE}, 2-bit encoding
  - the `CNT_WIDTH` default constant
- Single module with one combinational next-state/next-count process and one register process. No sub-module.
- All outputs come directly from registers.

## Test plan
- Continuous mode: start, compare=2, `en_i`=1 for 12 cycles -> ticks at cycles 4, 7, 10, 13; `busy_o`=1 throughout.
- One-shot mode: compare=3, start at cycle 0 -> exactly one tick at cycle 5; `done_o`=1 and `busy_o`=0 from cycle 5; count then holds at 0.
- `en_i` gating: compare=1, `en_i` toggling 1/0 each cycle -> tick every 4 cycles; count holds on disabled cycles.
- Load above compare: CNT_WIDTH=8, compare=5, load 0xFE in RUN -> count 0xFF, then 0x00 with no tick, counts to 5, next cycle 0 with tick.
- Priority: `clear_i`, `write_counter_i` and `start_i` asserted together in RUN -> IDLE, count 0, `done_o`=0. `stop_i` with `start_i` in RUN -> IDLE with count held.
- Reset mid-run: `rst_ni` low while count=7 in RUN -> all outputs 0 and state IDLE immediately; `start_i` after release resumes normal behaviour.
